// File: rtl/uart_frame_tx.sv
// uart_frame_tx: valid/ready UART transmitter, LSB-first, start bit, optional parity, 1 or 2 stop bits.
// Build option: define UART_TX_PARITY_EN to insert a parity bit whose sense is set by PARITY_ODD.
module uart_frame_tx #(
    parameter int CLK_DIV    = 100,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 TX,
    output logic                 busy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign tick  = (div_q == DIV_LAST);
    assign ready = (state_q == S_IDLE);
    assign busy  = ~ready;
    assign TX    = tx_q;

    // tx_d carries the level of the bit the next state will drive, so TX stays a plain flop.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_START;
                    shreg_d = data;
                    bit_d   = '0;
                    div_d   = '0;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^data) ^ PARITY_ODD[0];
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: three configurations, cycle-exact scoreboard of TX/ready/busy.
`timescale 1ns/1ps
module tb_uart_frame_tx;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PEN     = 1;
    localparam int GAP_EXP = 13;
`else
    localparam int PEN     = 0;
    localparam int GAP_EXP = 9;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] valid_v = '0;
    logic [7:0] d0 = '0;
    logic [7:0] d1 = '0;
    logic [6:0] d2 = '0;
    logic       tx0, tx1, tx2, rdy0, rdy1, rdy2, bsy0, bsy1, bsy2;
    logic [2:0] tx_v, rdy_v, busy_v;

    assign tx_v   = {tx2, tx1, tx0};
    assign rdy_v  = {rdy2, rdy1, rdy0};
    assign busy_v = {bsy2, bsy1, bsy0};

    always #5 CLK = ~CLK;

    uart_frame_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .CLK(CLK), .RST(RST), .data(d0), .valid(valid_v[0]), .ready(rdy0), .TX(tx0), .busy(bsy0));
    uart_frame_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
        .CLK(CLK), .RST(RST), .data(d1), .valid(valid_v[1]), .ready(rdy1), .TX(tx1), .busy(bsy1));
    uart_frame_tx #(.CLK_DIV(DIV), .DATA_BITS(7), .STOP_BITS(1), .PARITY_ODD(0)) u2 (
        .CLK(CLK), .RST(RST), .data(d2), .valid(valid_v[2]), .ready(rdy2), .TX(tx2), .busy(bsy2));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [15:0] pend_q [3][$];
    bit          exp_q  [3][$];
    int          mcnt   [3];

    typedef struct {
        int         inst;
        logic [8:0] word;
        logic       par;
    } vec_t;
    vec_t vecs [10];

    function automatic int nb_of(input int i);
        return (i == 2) ? 7 : 8;
    endfunction

    function automatic int sb_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int flen(input int i);
        return 1 + nb_of(i) + PEN + sb_of(i);
    endfunction

    // Frame bits in line order: index 0 is the start bit; unset upper bits stay 1 (stop/idle).
    function automatic logic [15:0] mk_frame(input int i, input logic [8:0] w, input logic p);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int b = 0; b < nb_of(i); b++) f[1+b] = w[b];
        if (PEN != 0) f[1+nb_of(i)] = p;
        return f;
    endfunction

    task automatic chk(input string nm, input int i, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %b want %b", nm, i, $time, got, want);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, got, want);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL timeout %s at %0t", nm, $time);
    endtask

    // Reference model: accepts when idle and valid, expands the pending frame into per-cycle TX levels.
    initial begin
        logic [15:0] f;
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                for (int i = 0; i < 3; i++) begin
                    exp_q[i].delete();
                    pend_q[i].delete();
                    mcnt[i] = 0;
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (mcnt[i] == 0 && valid_v[i]) begin
                        if (pend_q[i].size() == 0) begin
                            timeout("no pending frame for accept");
                        end else begin
                            f = pend_q[i].pop_front();
                            for (int b = 0; b < flen(i); b++)
                                for (int c = 0; c < DIV; c++) exp_q[i].push_back(f[b]);
                        end
                        mcnt[i] = flen(i) * DIV;
                    end else if (mcnt[i] > 0) begin
                        mcnt[i]--;
                    end
                end
            end
        end
    end

    initial begin
        bit et;
        wait (chk_en);
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 3; i++) begin
                if (exp_q[i].size() > 0) et = exp_q[i].pop_front();
                else et = 1'b1;
                chk("tx", i, tx_v[i], et);
                chk("ready", i, rdy_v[i], mcnt[i] == 0);
                chk("busy", i, busy_v[i], mcnt[i] != 0);
            end
        end
    end

    task automatic wait_accept(input int i);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (mcnt[i] != 0) done = 1'b1;
        end
        if (!done) timeout("accept");
    endtask

    task automatic wait_idle(input int i);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            if (mcnt[i] == 0 && exp_q[i].size() == 0) done = 1'b1;
        end
        if (!done) timeout("idle");
        repeat (3) @(negedge CLK);
    endtask

    task automatic send(input int i, input logic [8:0] w, input logic p);
        case (i)
            0:       d0 = w[7:0];
            1:       d1 = w[7:0];
            default: d2 = w[6:0];
        endcase
        pend_q[i].push_back(mk_frame(i, w, p));
        valid_v[i] = 1'b1;
        wait_accept(i);
        valid_v[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int  run, rhi;
        bit  saw, done;

        vecs[0] = '{0, 9'h061, 1'b1};
        vecs[1] = '{0, 9'h000, 1'b0};
        vecs[2] = '{0, 9'h0FF, 1'b0};
        vecs[3] = '{0, 9'h080, 1'b1};
        vecs[4] = '{0, 9'h001, 1'b1};
        vecs[5] = '{1, 9'h061, 1'b0};
        vecs[6] = '{1, 9'h03C, 1'b1};
        vecs[7] = '{2, 9'h02A, 1'b1};
        vecs[8] = '{2, 9'h040, 1'b1};
        vecs[9] = '{2, 9'h003, 1'b0};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST    = 1'b0;
        chk_en = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_tx", i, tx_v[i], 1'b1);
            chk("rst_ready", i, rdy_v[i], 1'b1);
            chk("rst_busy", i, busy_v[i], 1'b0);
        end
        repeat (50) @(negedge CLK);

        for (int k = 0; k < 10; k++) begin
            send(vecs[k].inst, vecs[k].word, vecs[k].par);
            wait_idle(vecs[k].inst);
        end

        // Request during DATA is dropped and data changes do not reach the frame in flight.
        send(0, 9'h061, 1'b1);
        repeat (9) @(negedge CLK);
        d0 = 8'hFF;
        valid_v[0] = 1'b1;
        @(negedge CLK);
        valid_v[0] = 1'b0;
        d0 = 8'h00;
        repeat (8) @(negedge CLK);
        d0 = 8'hA5;
        wait_idle(0);
        repeat (50) @(negedge CLK);
        chk("ignored_ready", 0, rdy_v[0], 1'b1);

        // Back-to-back frames with valid held high on the 2-stop-bit instance.
        d1 = 8'h55;
        pend_q[1].push_back(mk_frame(1, 9'h055, 1'b1));
        pend_q[1].push_back(mk_frame(1, 9'h0A0, 1'b1));
        valid_v[1] = 1'b1;
        wait_accept(1);
        d1 = 8'hA0;
        run = 0; rhi = 0; saw = 1'b0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            if (saw && !tx_v[1]) begin
                done = 1'b1;
            end else begin
                if (tx_v[1]) run++;
                else run = 0;
                if (rdy_v[1]) begin
                    saw = 1'b1;
                    rhi++;
                end
            end
        end
        valid_v[1] = 1'b0;
        if (!done) timeout("second start bit");
        chk_int("b2b_gap_cycles", run, GAP_EXP);
        chk_int("b2b_ready_to_start", rhi, 1);
        wait_idle(1);

        // Reset during the third data bit (a 0 bit) of a 7-bit frame, then a clean frame.
        send(2, 9'h03B, 1'b1);
        repeat (13) @(negedge CLK);
        #1;
        chk("pre_reset_tx", 2, tx_v[2], 1'b0);
        RST = 1'b1;
        #1;
        chk("async_rst_tx", 2, tx_v[2], 1'b1);
        chk("async_rst_ready", 2, rdy_v[2], 1'b1);
        chk("async_rst_busy", 2, busy_v[2], 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        send(2, 9'h02A, 1'b1);
        wait_idle(2);
        repeat (20) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised UART transmitter: accepts a word over a valid/ready handshake and serialises it LSB-first on `TX` with start bit, optional parity and 1 or 2 stop bits. It generates its own bit timing from the system clock with an internal divisor, so no separate divided clock is needed. It replaces the fixed 8N1 sender in the board top-level and is driven by debounced button strobes or any other producer.

## Interface
- `CLK_DIV`, default 100: system clock cycles per bit; legal range ≥ 2. Example: 50 MHz / 500 k = 100.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Used only when `UART_TX_PARITY_EN` is defined.
- `CLK  input  1`: single clock; all logic is rising-edge.
- `RST  input  1`: reset, asynchronous and active-high.
- `data  input  DATA_BITS`: word to send. Sampled only on the accept edge.
- `valid  input  1`: producer has a word.
- `ready  output  1`: block can accept a word. High only in IDLE.
- `TX  output  1`: serial line. Idles high. Registered output, glitch-free.
- `busy  output  1`: frame in progress; equal to not `ready`.

## Operation
- States: IDLE, START, DATA, PARITY (only with `UART_TX_PARITY_EN`), STOP.
- **IDLE**
  - `TX`=1, `ready`=1.
  - Accept happens on a rising edge where `valid` && `ready` are both high.
  - On accept: latch `data` into the shift register, clear the bit counter and divisor counter, and go to START.
- **START**
  - `TX`=0 for `CLK_DIV` cycles, then go to DATA.
- **DATA**
  - `TX` = shreg[0]; shift right every `CLK_DIV` cycles.
  - After `DATA_BITS` bits:
    - go to PARITY if enabled,
    - otherwise go to STOP.
- **PARITY**
  - `TX` = XOR of the latched word, XOR `PARITY_ODD`. Held `CLK_DIV` cycles, then go to STOP.
- **STOP**
  - `TX`=1 for `STOP_BITS`×`CLK_DIV` cycles, then go to IDLE.
- Divisor counter:
  - width `$clog2(CLK_DIV)`;
  - counts 0..`CLK_DIV`-1 and wraps at the terminal count;
  - the bit advance occurs on the terminal count.
- Bit counter width: `$clog2(DATA_BITS+1)`. Stop-bit counting reuses it.
- Input handling outside the accept edge:
  - `valid` outside IDLE is ignored; the word is not queued.
  - `data` changes after accept have no effect on the frame in flight.
- Reset asserted mid-frame:
  - the frame is aborted immediately (asynchronously);
  - `TX` goes to 1, state to IDLE;
  - no partial frame resumes after reset release.

## Timing
- Reset values: `TX`=1, `ready`=1, `busy`=0. All counters are 0, state is IDLE.
- Accept edge: edge N.
  - `TX` falls at edge N (visible in cycle N+1).
  - `ready` and `busy` update on the same edge.
- Each bit lasts exactly `CLK_DIV` cycles.
- Frame length: F = (1 + `DATA_BITS` + P + `STOP_BITS`) × `CLK_DIV` cycles, where P = 1 with parity, 0 without.
- `ready` returns high at edge N+F.
- Back-to-back frames (`valid` held high):
  - the next accept is at edge N+F+1;
  - the line therefore idles high for the stop time plus exactly 1 cycle between frames.
- No combinational path from `valid` or `data` to `TX`.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state and parity logic are compiled in. One parity bit is sent between the data bits and the stop bits; its sense is set by `PARITY_ODD`.
  - Undefined: the PARITY state, parity logic and `PARITY_ODD` usage are removed. Frames are 1 + `DATA_BITS` + `STOP_BITS` bits long.

## Test plan
- **Reset idle:** assert `RST` for 3 cycles, then release with `valid`=0 → `TX`=1, `ready`=1, `busy`=0 for 50 cycles.
- **Basic 8N1 frame:** `CLK_DIV`=4, `DATA_BITS`=8, no parity; send 8'h61 → `TX` sequence per 4-cycle bit is 0, 1,0,0,0,0,1,1,0, 1. `ready` returns at 40 cycles after accept.
- **Parity frame:** `UART_TX_PARITY_EN` defined, `CLK_DIV`=4, 8'h61.
  - `PARITY_ODD`=0 → parity bit 1.
  - `PARITY_ODD`=1 → parity bit 0.
  - Frame length 44 cycles.
- **Back-to-back with 2 stop bits:** `valid` held high, words 8'h55 then 8'hA0, `STOP_BITS`=2, `CLK_DIV`=4.
  - Second start bit begins 1 cycle after `ready` rises.
  - High time between the two frames is 9 cycles.
  - Both words decode correctly.
- **Ignored request and data change:** pulse `valid` with 8'hFF during DATA, and change `data` mid-frame → no second frame is sent, and the in-flight word is unchanged.
- **Reset mid-frame:** assert `RST` during the 3rd data bit → `TX`=1 and `ready`=1 in the same cycle. After release, a new 7-bit word (`DATA_BITS`=7, 7'h2A) is sent as a complete, correct frame.
